prop_window_monitor: RTL and testbench
======================================

# prop_window_monitor

Synthesizable downstream checker for the XOR DUT output stage. It watches the DUT inputs `a`, `b` and output `d` each clock and evaluates the property "`a && b` implies `d` within `MIN_DLY..MAX_DLY` cycles" in hardware. Every trigger is tracked as an independent overlapping attempt, and the block reports pass/fail pulses and saturating counts. It replaces simulator-only concurrent assertions where a gate-level or emulation run needs the same check.

## Interface
- `MIN_DLY`, default 1: earliest cycle after the trigger at which `d` satisfies the attempt; legal range 1..MAX_DLY.
- `MAX_DLY`, default 3: last cycle at which `d` satisfies the attempt; legal range MIN_DLY..15.
- `CNT_W`, default 16: width of the pass and fail counters.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  permits new attempts; attempts already pending continue regardless of `en`.
- `clr`  in  1  synchronous clear of counters and pending attempts.
- `a`, `b`  in  1  trigger inputs.
- `d`  in  1  DUT response.
- `pass_pulse`  out  1  one-cycle strobe: at least one attempt passed.
- `fail_pulse`  out  1  one-cycle strobe: an attempt expired.
- `busy`  out  1  at least one attempt pending.
- `pass_cnt`  out  CNT_W  saturating count of passed attempts.
- `fail_cnt`  out  CNT_W  saturating count of failed attempts.

## Operation
- Pending vector `pend[1..MAX_DLY]`. Bit k set means an unresolved attempt will be age k at the next edge.
- At each edge, using sampled inputs:
  - `hit[k] = pend[k] & d` for k in MIN_DLY..MAX_DLY.
  - `expire = pend[MAX_DLY] & ~d`.
  - `pend[1] <= en & a & b`.
  - `pend[k+1] <= pend[k] & ~hit[k]` for k < MAX_DLY.
- A single high `d` satisfies every pending attempt that is in its window. The pass count for that cycle is `popcount(hit)`.
- `pass_cnt` adds `popcount(hit)` and `fail_cnt` adds `expire`. Both saturate at all-ones and never wrap.
- `d` sampled on the same edge as the trigger never satisfies that trigger's attempt.
- `clr` has priority over all updates. It zeroes `pend`, both counters and both pulses on the next edge.
- `rst` asserted mid-window discards pending attempts without reporting fail.
- Reset values: all outputs 0 and `pend` 0.

## Timing
- Trigger sampled at edge t. Its attempt is checked against `d` at edges t+MIN_DLY .. t+MAX_DLY.
- `pass_pulse` and `fail_pulse` are registered. Each is high for the cycle following the deciding edge, so latency is 1 cycle.
- Counters update on the same edge that raises the pulse.
- `busy` is registered as `|pend`.
- A trigger can start every cycle, so the maximum number of outstanding attempts is MAX_DLY.
- A pass and a fail from different attempts can occur at the same edge only when `d`=0 at that edge. In that case the pass pulse is impossible, because a pass requires `d`=1. `pass_pulse` and `fail_pulse` are therefore mutually exclusive.

## Configuration
- Macro: `PROP_MON_FAIL_CAPTURE_EN`.
- Defined: the block adds a free-running `CNT_W` cycle stamp (reset 0, wraps) and two extra outputs:
  - `first_fail_vld` (out, 1): sticky flag, set on the first expire.
  - `first_fail_stamp` (out, CNT_W): stamp value of the trigger edge of the first failing attempt, computed as stamp − MAX_DLY, modulo 2^CNT_W.
  - Both extra outputs are cleared only by `rst` or `clr`.
- Undefined: these ports, the stamp counter and the capture logic are absent. All other behaviour is identical.

## Structure
- `prop_mon_pkg` holds:
  - default `CNT_W`;
  - `MAX_DLY_LIMIT` = 15;
  - the popcount function;
  - typedef `cnt_t` of `logic [CNT_W-1:0]`.
- Sub-module `prop_mon_sat_cnt` is a saturating counter with an increment-amount input and a synchronous clear. It is instantiated twice, for pass and fail.
- Parameter legality is checked by an elaboration-time error.

## Test plan
All scenarios use MIN_DLY=1, MAX_DLY=3, CNT_W=16 unless stated.
- **Single pass:** a=b=1 at edge 0 only, d=1 at edge 2 → `pass_pulse` high in the cycle after edge 2, `pass_cnt`=1, `fail_cnt`=0, `busy` low after edge 2.
- **Expiry:** trigger at edge 0, d=0 through edge 3 → `fail_pulse` in the cycle after edge 3, `fail_cnt`=1.
- **Overlap:** a=b=1 at edges 0, 1 and 2, d=1 only at edge 3 → one `pass_pulse`, `pass_cnt` jumps 0→3 in one update, no fail.
- **Same-edge d:** trigger at edge 0 with d=1 at edge 0 only → no pass; fail at edge 3 (`fail_cnt`=1).
- **Saturation:** CNT_W=4, 20 consecutive passes → `pass_cnt` holds at 15.
- **Reset and clear:** `rst` pulsed between edges 1 and 2 of a pending attempt → no fail, all outputs 0. `clr` in the same position → counters 0 at the next edge, no fail.
- **Macro:** with `PROP_MON_FAIL_CAPTURE_EN` defined, run Expiry after 5 idle cycles → `first_fail_vld`=1, `first_fail_stamp`=5.

Source files
------------

// File: rtl/prop_window_monitor_pkg.sv
// prop_mon_pkg: shared definitions for the property window monitor.
//   CNT_W_DEFAULT : default width of the pass/fail counters
//   MAX_DLY_LIMIT : largest supported response window (cycles)
//   POP_W         : width of a popcount over MAX_DLY_LIMIT bits
//   cnt_t         : counter type at the default width
//   popcount()    : number of set bits in a window-sized vector
package prop_mon_pkg;

  localparam int CNT_W_DEFAULT = 16;
  localparam int MAX_DLY_LIMIT = 15;
  localparam int POP_W         = 4;

  typedef logic [CNT_W_DEFAULT-1:0] cnt_t;

  // Number of attempts resolved in one cycle; at most MAX_DLY_LIMIT, so
  // POP_W bits always suffice.
  function automatic logic [POP_W-1:0] popcount(input logic [MAX_DLY_LIMIT-1:0] v);
    logic [POP_W-1:0] s;
    s = '0;
    for (int i = 0; i < MAX_DLY_LIMIT; i++) begin
      s = s + POP_W'(v[i]);
    end
    return s;
  endfunction

endpackage

// File: rtl/prop_window_monitor_if.sv
// prop_window_monitor_if: observed signals and result outputs of the
// property window monitor.
//   Parameter CNT_W : width of the pass/fail counters.
//   Inputs to the monitor : en, clr, a, b, d
//   Outputs of the monitor: pass_pulse, fail_pulse, busy, pass_cnt, fail_cnt
//   With PROP_MON_FAIL_CAPTURE_EN defined: first_fail_vld, first_fail_stamp
// Modports: master (environment side, drives the inputs), slave (monitor).
interface prop_window_monitor_if #(
  parameter int CNT_W = 16
) ();

  logic             en;
  logic             clr;
  logic             a;
  logic             b;
  logic             d;
  logic             pass_pulse;
  logic             fail_pulse;
  logic             busy;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;

`ifdef PROP_MON_FAIL_CAPTURE_EN
  logic             first_fail_vld;
  logic [CNT_W-1:0] first_fail_stamp;

  modport master (
    output en, clr, a, b, d,
    input  pass_pulse, fail_pulse, busy, pass_cnt, fail_cnt,
    input  first_fail_vld, first_fail_stamp
  );

  modport slave (
    input  en, clr, a, b, d,
    output pass_pulse, fail_pulse, busy, pass_cnt, fail_cnt,
    output first_fail_vld, first_fail_stamp
  );
`else
  modport master (
    output en, clr, a, b, d,
    input  pass_pulse, fail_pulse, busy, pass_cnt, fail_cnt
  );

  modport slave (
    input  en, clr, a, b, d,
    output pass_pulse, fail_pulse, busy, pass_cnt, fail_cnt
  );
`endif

endinterface

// File: rtl/prop_window_monitor_sat_cnt.sv
// prop_mon_sat_cnt: saturating up-counter with a multi-bit increment.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (count to 0)
//   clr  : synchronous clear (count to 0), wins over increment
//   inc  : amount added this cycle
//   q    : current count, holds at all-ones instead of wrapping
module prop_mon_sat_cnt #(
  parameter int W     = 16,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [INC_W-1:0] inc,
  output logic [W-1:0]     q
);

  // One spare bit above the wider operand so the overflow is visible.
  localparam int SUM_W = ((W > INC_W) ? W : INC_W) + 1;
  localparam logic [SUM_W-1:0] SAT = (SUM_W'(1) << W) - SUM_W'(1);

  logic [SUM_W-1:0] sum;

  assign sum = SUM_W'(q) + SUM_W'(inc);

  // Accumulate; clamp to all-ones once the true sum passes the maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (sum > SAT) begin
      q <= '1;
    end else begin
      q <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/prop_window_monitor.sv
// prop_window_monitor: hardware checker for "a && b implies d within
// MIN_DLY..MAX_DLY cycles". Each trigger is an independent, overlapping
// attempt; results are reported as registered pulses and saturating counts.
//   Parameters: MIN_DLY (1..MAX_DLY), MAX_DLY (MIN_DLY..15), CNT_W
//   clk : clock, rising edge
//   rst : asynchronous active-high reset; discards pending attempts silently
//   mon : prop_window_monitor_if.slave
//         en/clr/a/b/d in; pass_pulse/fail_pulse/busy/pass_cnt/fail_cnt out
// Optional feature, macro PROP_MON_FAIL_CAPTURE_EN: free-running cycle stamp
// and capture of the trigger stamp of the first failing attempt
// (first_fail_vld, first_fail_stamp).
module prop_window_monitor
  import prop_mon_pkg::*;
#(
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 3,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  prop_window_monitor_if.slave  mon
);

  if (MIN_DLY < 1 || MAX_DLY < MIN_DLY || MAX_DLY > MAX_DLY_LIMIT || CNT_W < 1) begin : g_param_err
    $error("prop_window_monitor: need 1 <= MIN_DLY <= MAX_DLY <= 15 and CNT_W >= 1");
  end

  // pend[k]: an unresolved attempt that will be age k at the next edge.
  logic [MAX_DLY:1]       pend;
  logic [MAX_DLY:1]       pend_nxt;
  logic [MAX_DLY_LIMIT:1] hit;
  logic                   expire;
  logic                   trig;
  logic                   d_in;
  logic                   clr_in;
  logic [POP_W-1:0]       pass_inc;
  logic                   pass_pulse_q;
  logic                   fail_pulse_q;
  logic                   busy_q;
  logic [CNT_W-1:0]       pass_cnt_q;
  logic [CNT_W-1:0]       fail_cnt_q;

  assign trig   = mon.en & mon.a & mon.b;
  assign d_in   = mon.d;
  assign clr_in = mon.clr;

  // A high d resolves every attempt inside its window at once. The newest
  // trigger only enters pend[1] at this edge, so d sampled together with the
  // trigger can never satisfy it. An attempt reaching MAX_DLY with d low
  // expires instead of ageing further.
  always_comb begin
    hit         = '0;
    pend_nxt    = '0;
    pend_nxt[1] = trig;
    for (int k = 1; k <= MAX_DLY; k++) begin
      if (k >= MIN_DLY) begin
        hit[k] = pend[k] & d_in;
      end
    end
    for (int k = 1; k < MAX_DLY; k++) begin
      pend_nxt[k+1] = pend[k] & ~hit[k];
    end
  end

  assign expire   = pend[MAX_DLY] & ~d_in;
  assign pass_inc = popcount(hit);

  // busy follows the new pend value so it drops on the edge that resolves
  // the last attempt, not one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend         <= '0;
      pass_pulse_q <= 1'b0;
      fail_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
    end else if (clr_in) begin
      pend         <= '0;
      pass_pulse_q <= 1'b0;
      fail_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      pend         <= pend_nxt;
      pass_pulse_q <= |hit;
      fail_pulse_q <= expire;
      busy_q       <= |pend_nxt;
    end
  end

  prop_mon_sat_cnt #(
    .W     (CNT_W),
    .INC_W (POP_W)
  ) u_pass_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_in),
    .inc (pass_inc),
    .q   (pass_cnt_q)
  );

  prop_mon_sat_cnt #(
    .W     (CNT_W),
    .INC_W (1)
  ) u_fail_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_in),
    .inc (expire),
    .q   (fail_cnt_q)
  );

  assign mon.pass_pulse = pass_pulse_q;
  assign mon.fail_pulse = fail_pulse_q;
  assign mon.busy       = busy_q;
  assign mon.pass_cnt   = pass_cnt_q;
  assign mon.fail_cnt   = fail_cnt_q;

`ifdef PROP_MON_FAIL_CAPTURE_EN
  logic [CNT_W-1:0] stamp;
  logic             ff_vld;
  logic [CNT_W-1:0] ff_stamp;

  // Free-running cycle stamp; clr deliberately leaves it running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stamp <= '0;
    end else begin
      stamp <= stamp + CNT_W'(1);
    end
  end

  // The expiring attempt was triggered MAX_DLY edges before this one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_vld   <= 1'b0;
      ff_stamp <= '0;
    end else if (clr_in) begin
      ff_vld   <= 1'b0;
      ff_stamp <= '0;
    end else if (expire && !ff_vld) begin
      ff_vld   <= 1'b1;
      ff_stamp <= stamp - CNT_W'(MAX_DLY);
    end
  end

  assign mon.first_fail_vld   = ff_vld;
  assign mon.first_fail_stamp = ff_stamp;
`endif

endmodule

// File: tb/tb_prop_window_monitor.sv
// tb_prop_window_monitor: directed self-checking bench for prop_window_monitor.
// Two instances share the stimulus: the main one (CNT_W=16) and a narrow one
// (CNT_W=4) used for the saturation scenario. Both use MIN_DLY=1, MAX_DLY=3.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_prop_window_monitor;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;

  prop_window_monitor_if #(.CNT_W(16)) mon_if ();
  prop_window_monitor_if #(.CNT_W(4))  sat_if ();

  assign sat_if.en  = mon_if.en;
  assign sat_if.clr = mon_if.clr;
  assign sat_if.a   = mon_if.a;
  assign sat_if.b   = mon_if.b;
  assign sat_if.d   = mon_if.d;

  prop_window_monitor #(.MIN_DLY(1), .MAX_DLY(3), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .mon (mon_if)
  );

  prop_window_monitor #(.MIN_DLY(1), .MAX_DLY(3), .CNT_W(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .mon (sat_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation and tally it.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Present one cycle of inputs, take the edge, settle 1 unit past it.
  task automatic applyStimulus(input logic en_v, input logic a_v, input logic b_v,
                               input logic d_v, input logic clr_v);
    mon_if.en  = en_v;
    mon_if.a   = a_v;
    mon_if.b   = b_v;
    mon_if.d   = d_v;
    mon_if.clr = clr_v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst        = 1'b1;
    mon_if.en  = 1'b0;
    mon_if.a   = 1'b0;
    mon_if.b   = 1'b0;
    mon_if.d   = 1'b0;
    mon_if.clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    checkOutput("rst_pass_pulse", 32'(mon_if.pass_pulse), 0);
    checkOutput("rst_fail_pulse", 32'(mon_if.fail_pulse), 0);
    checkOutput("rst_busy",       32'(mon_if.busy), 0);
    checkOutput("rst_pass_cnt",   32'(mon_if.pass_cnt), 0);
    checkOutput("rst_fail_cnt",   32'(mon_if.fail_cnt), 0);
    rst = 1'b0;

    // Single pass: trigger at edge 0, d at edge 2
    applyStimulus(1, 1, 1, 0, 0);
    checkOutput("sp_busy_e0",  32'(mon_if.busy), 1);
    checkOutput("sp_pulse_e0", 32'(mon_if.pass_pulse), 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("sp_pass_pulse", 32'(mon_if.pass_pulse), 1);
    checkOutput("sp_pass_cnt",   32'(mon_if.pass_cnt), 1);
    checkOutput("sp_fail_cnt",   32'(mon_if.fail_cnt), 0);
    checkOutput("sp_busy_done",  32'(mon_if.busy), 0);
    idle(1);
    checkOutput("sp_pulse_drop", 32'(mon_if.pass_pulse), 0);

    // Expiry: trigger at edge 0, d low through edge 3
    applyStimulus(1, 1, 1, 0, 0);
    idle(2);
    checkOutput("ex_no_early_fail", 32'(mon_if.fail_pulse), 0);
    idle(1);
    checkOutput("ex_fail_pulse", 32'(mon_if.fail_pulse), 1);
    checkOutput("ex_fail_cnt",   32'(mon_if.fail_cnt), 1);
    checkOutput("ex_pass_cnt",   32'(mon_if.pass_cnt), 1);
    checkOutput("ex_busy",       32'(mon_if.busy), 0);

    // Overlap: triggers at edges 0,1,2 and d only at edge 3 -> +3 at once
    applyStimulus(1, 1, 1, 0, 0);
    applyStimulus(1, 1, 1, 0, 0);
    applyStimulus(1, 1, 1, 0, 0);
    checkOutput("ov_cnt_before", 32'(mon_if.pass_cnt), 1);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("ov_pass_pulse", 32'(mon_if.pass_pulse), 1);
    checkOutput("ov_pass_cnt",   32'(mon_if.pass_cnt), 4);
    checkOutput("ov_fail_pulse", 32'(mon_if.fail_pulse), 0);
    idle(3);
    checkOutput("ov_fail_cnt", 32'(mon_if.fail_cnt), 1);
    checkOutput("ov_busy",     32'(mon_if.busy), 0);

    // Same-edge d does not satisfy its own trigger
    applyStimulus(1, 1, 1, 1, 0);
    checkOutput("se_no_pass", 32'(mon_if.pass_pulse), 0);
    idle(3);
    checkOutput("se_fail_pulse", 32'(mon_if.fail_pulse), 1);
    checkOutput("se_fail_cnt",   32'(mon_if.fail_cnt), 2);
    checkOutput("se_pass_cnt",   32'(mon_if.pass_cnt), 4);

    // en low blocks new attempts
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("en_busy", 32'(mon_if.busy), 0);
    idle(3);
    checkOutput("en_fail_cnt", 32'(mon_if.fail_cnt), 2);

    // Reset mid-window: discards attempt without a fail
    applyStimulus(1, 1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    rst = 1'b1;
    #2;
    checkOutput("rm_busy",     32'(mon_if.busy), 0);
    checkOutput("rm_pass_cnt", 32'(mon_if.pass_cnt), 0);
    checkOutput("rm_fail_cnt", 32'(mon_if.fail_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);
    checkOutput("rm_no_fail_cnt", 32'(mon_if.fail_cnt), 0);
    checkOutput("rm_no_fail",     32'(mon_if.fail_pulse), 0);

    // Clear mid-window: counters zeroed, no later fail
    applyStimulus(1, 1, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("cl_pre_cnt", 32'(mon_if.pass_cnt), 1);
    applyStimulus(1, 1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("cl_pass_cnt", 32'(mon_if.pass_cnt), 0);
    checkOutput("cl_busy",     32'(mon_if.busy), 0);
    idle(1);
    checkOutput("cl_no_fail_pulse", 32'(mon_if.fail_pulse), 0);
    idle(2);
    checkOutput("cl_fail_cnt", 32'(mon_if.fail_cnt), 0);

    // Saturation: 21 trigger+d cycles give 20 passes
    applyStimulus(1, 0, 0, 0, 1);
    for (int i = 0; i < 21; i++) applyStimulus(1, 1, 1, 1, 0);
    checkOutput("sat_main_cnt", 32'(mon_if.pass_cnt), 20);
    checkOutput("sat_narrow_cnt", 32'(sat_if.pass_cnt), 15);
    checkOutput("sat_narrow_pulse", 32'(sat_if.pass_pulse), 1);
    applyStimulus(1, 1, 1, 1, 0);
    checkOutput("sat_narrow_hold", 32'(sat_if.pass_cnt), 15);
    checkOutput("sat_narrow_fail", 32'(sat_if.fail_cnt), 0);

`ifdef PROP_MON_FAIL_CAPTURE_EN
    // First-fail capture: 5 idle edges, trigger stamped 5, expires at 8
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(5);
    applyStimulus(1, 1, 1, 0, 0);
    idle(2);
    checkOutput("ff_vld_early", 32'(mon_if.first_fail_vld), 0);
    idle(1);
    checkOutput("ff_vld",   32'(mon_if.first_fail_vld), 1);
    checkOutput("ff_stamp", 32'(mon_if.first_fail_stamp), 5);
    applyStimulus(1, 1, 1, 0, 0);
    idle(3);
    checkOutput("ff_stamp_sticky", 32'(mon_if.first_fail_stamp), 5);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
